// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer
//   Read sequencer for the RTC bus. A start pulse makes it write NUM_CMDS
//   transfer commands (CMD_DATA to CMD_BASE+i). It then reads every slot
//   whose rd_mask bit is set, using the address taken from rd_addr_list.
//   Each bus transaction uses a req/ack handshake and has its own watchdog.
//
//   Optional build macro: ATOMIC_UPDATE_EN
//     defined   - reads are collected in a shadow bank. rd_data is updated
//                 from the shadow bank only in the cycle that done pulses.
//     undefined - each rd_data slot is updated in the cycle after its ack.
//
// Ports
//   clk, reset    : clock and synchronous active-high reset
//   start         : one-cycle pulse that starts a sequence (ignored when busy)
//   abort         : level input that cancels a running sequence
//   rd_addr_list  : address for each slot, slot i at [i*ADDR_W +: ADDR_W]
//   rd_mask       : bit i = 1 reads slot i, 0 skips it
//   bus_req/we/addr/wdata : transaction request to the bus controller
//   bus_ack/rdata : completion pulse and read data from the bus controller
//   rd_data       : read data bank, slot i at [i*DATA_W +: DATA_W]
//   busy          : high whenever the sequencer is not idle
//   done/err/aborted : one-cycle pulses for completion, timeout and abort
module rtc_read_sequencer #(
    parameter int                NUM_REGS    = 9,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                NUM_CMDS    = 2,
    parameter logic [ADDR_W-1:0] CMD_BASE    = 8'hF1,
    parameter logic [DATA_W-1:0] CMD_DATA    = 8'h00,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_REGS*ADDR_W-1:0]   rd_addr_list,
    input  logic [NUM_REGS-1:0]          rd_mask,
    output logic                         bus_req,
    output logic                         bus_we,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [DATA_W-1:0]            bus_wdata,
    input  logic                         bus_ack,
    input  logic [DATA_W-1:0]            bus_rdata,
    output logic [NUM_REGS*DATA_W-1:0]   rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         aborted
);
    localparam int SLOT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_READ, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   cmd_idx_q, cmd_idx_d;
    logic [SLOT_W-1:0]            slot_q, slot_d;
    logic [WDOG_W-1:0]            wdog_q, wdog_d;
    logic [NUM_REGS-1:0]          mask_q, mask_d;
    logic [NUM_REGS*ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_REGS*DATA_W-1:0]   rd_data_q, rd_data_d;
`ifdef ATOMIC_UPDATE_EN
    logic [NUM_REGS*DATA_W-1:0]   shadow_q, shadow_d;
`endif
    logic                         bus_req_q, bus_req_d;
    logic                         bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]            bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]            bus_wdata_q, bus_wdata_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         aborted_q, aborted_d;

    logic                         timeout;
    logic [SLOT_W:0]              nxt_slot, cmd_first, start_first;

    // Returns the lowest set mask bit at or above 'from' as {found, index}.
    function automatic logic [SLOT_W:0] first_set(input logic [NUM_REGS-1:0] m,
                                                  input int from);
        logic [SLOT_W:0] r;
        r = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (i >= from && m[i]) begin
                r = {1'b1, SLOT_W'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cmd_idx_d = cmd_idx_q;
        slot_d    = slot_q;
        wdog_d    = wdog_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
`ifdef ATOMIC_UPDATE_EN
        shadow_d  = shadow_q;
`endif
        done_d    = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;

        // An ack in the same cycle as the limit takes priority, because the ack branch is checked first.
        timeout     = (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));
        nxt_slot    = first_set(mask_q, int'(slot_q) + 1);
        cmd_first   = first_set(mask_q, 0);
        start_first = first_set(rd_mask, 0);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mask_d    = rd_mask;
                    addr_d    = rd_addr_list;
                    cmd_idx_d = '0;
                    wdog_d    = '0;
`ifdef ATOMIC_UPDATE_EN
                    // Seed the shadow bank so skipped slots keep their current value on commit.
                    shadow_d  = rd_data_q;
`endif
                    if (NUM_CMDS > 0) begin
                        state_d = S_CMD;
                    end else if (start_first[SLOT_W]) begin
                        state_d = S_READ;
                        slot_d  = start_first[SLOT_W-1:0];
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CMD: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    wdog_d    = '0;
                end else if (bus_ack) begin
                    wdog_d = '0;
                    if (int'(cmd_idx_q) == NUM_CMDS - 1) begin
                        if (cmd_first[SLOT_W]) begin
                            state_d = S_READ;
                            slot_d  = cmd_first[SLOT_W-1:0];
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cmd_idx_d = cmd_idx_q + 3'd1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    wdog_d    = '0;
                end else if (bus_ack) begin
                    wdog_d = '0;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (slot_q == SLOT_W'(i)) begin
`ifdef ATOMIC_UPDATE_EN
                            shadow_d[i*DATA_W +: DATA_W] = bus_rdata;
`else
                            rd_data_d[i*DATA_W +: DATA_W] = bus_rdata;
`endif
                        end
                    end
                    if (nxt_slot[SLOT_W]) begin
                        slot_d = nxt_slot[SLOT_W-1:0];
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_DONE: begin
                // Abort in this state has no effect, so done still pulses.
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef ATOMIC_UPDATE_EN
                rd_data_d = shadow_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // The bus outputs are registered and show the transaction of the state being entered.
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        if (state_d == S_CMD) begin
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b1;
            bus_addr_d  = CMD_BASE + ADDR_W'(cmd_idx_d);
            bus_wdata_d = CMD_DATA;
        end else if (state_d == S_READ) begin
            bus_req_d = 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (slot_d == SLOT_W'(i)) begin
                    bus_addr_d = addr_d[i*ADDR_W +: ADDR_W];
                end
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_idx_q   <= '0;
            slot_q      <= '0;
            wdog_q      <= '0;
            mask_q      <= '0;
            addr_q      <= '0;
            rd_data_q   <= '0;
`ifdef ATOMIC_UPDATE_EN
            shadow_q    <= '0;
`endif
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_idx_q   <= cmd_idx_d;
            slot_q      <= slot_d;
            wdog_q      <= wdog_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
`ifdef ATOMIC_UPDATE_EN
            shadow_q    <= shadow_d;
`endif
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Testbench for rtc_read_sequencer. The bench acts as the bus controller.
// Expected transactions and expected read-bank contents are derived from
// the mask, the address list and the data returned on the bus.
`timescale 1ns/1ps
module tb_rtc_read_sequencer;
    localparam int NR = 9, DW = 8, AW = 8, NC = 2, TO = 255;
    localparam logic [AW-1:0] CB = 8'hF1;
    localparam logic [DW-1:0] CD = 8'h00;
    localparam int NR0 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, abort, bus_ack;
    logic [NR*AW-1:0]  addr_list;
    logic [NR-1:0]     mask;
    logic [DW-1:0]     bus_rdata;
    logic              bus_req, bus_we, busy, done, err, aborted;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [NR*DW-1:0]  rd_data;

    rtc_read_sequencer #(
        .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .NUM_CMDS(NC),
        .CMD_BASE(CB), .CMD_DATA(CD), .TIMEOUT_CYC(TO)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_addr_list(addr_list), .rd_mask(mask),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .aborted(aborted)
    );

    // Second instance with no command phase, used for the empty-mask case.
    logic               start0, abort0, ack0;
    logic [NR0*AW-1:0]  addr0;
    logic [NR0-1:0]     mask0;
    logic [DW-1:0]      rdata0;
    logic               req0, we0, busy0, done0, err0, aborted0;
    logic [AW-1:0]      baddr0;
    logic [DW-1:0]      wdata0;
    logic [NR0*DW-1:0]  rd_data0;

    rtc_read_sequencer #(
        .NUM_REGS(NR0), .DATA_W(DW), .ADDR_W(AW), .NUM_CMDS(0),
        .CMD_BASE(CB), .CMD_DATA(CD), .TIMEOUT_CYC(TO)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .rd_addr_list(addr0), .rd_mask(mask0),
        .bus_req(req0), .bus_we(we0), .bus_addr(baddr0), .bus_wdata(wdata0),
        .bus_ack(ack0), .bus_rdata(rdata0), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .err(err0), .aborted(aborted0)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    slot;
    } txn_t;

    txn_t        exp_q[$];
    logic [DW-1:0] model   [NR];   // expected visible rd_data
    logic [DW-1:0] shadow_m[NR];   // reads of the running sequence
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    // Expected transaction list: the command writes, then the enabled slots in ascending order.
    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < NC; i++) exp_q.push_back('{1'b1, CB + AW'(i), 4'd0});
        for (int s = 0; s < NR; s++)
            if (mask[s]) exp_q.push_back('{1'b0, addr_list[s*AW +: AW], 4'(s)});
        for (int i = 0; i < NR; i++) shadow_m[i] = model[i];
    endtask

    task automatic record_read(input int slot, input logic [DW-1:0] val);
`ifdef ATOMIC_UPDATE_EN
        shadow_m[slot] = val;
`else
        model[slot] = val;
`endif
    endtask

    task automatic commit_done();
`ifdef ATOMIC_UPDATE_EN
        for (int i = 0; i < NR; i++) model[i] = shadow_m[i];
`endif
    endtask

    // rdmode: 0 = random data, 1 = address+1, 2 = 0xAA. withhold: index of the transaction that never gets an ack (-1 for none).
    task automatic run_seq(input int dlo, input int dhi, input int rdmode, input int withhold);
        int d;
        logic [DW-1:0] rd;
        build_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < exp_q.size(); t++) begin
            chk("txn_req", bus_req, 1'b1);
            chk("txn_we", bus_we, exp_q[t].we);
            chk("txn_addr", bus_addr, exp_q[t].addr);
            chk("txn_wdata", bus_wdata, exp_q[t].we ? CD : DW'(0));
            if (t == withhold) begin
                for (int k = 1; k <= TO; k++) begin
                    @(negedge clk);
                    if (k == TO - 1) begin
                        chk("wdog_not_yet", err, 1'b0);
                        chk("wdog_req_held", bus_req, 1'b1);
                    end
                    if (k == TO) begin
                        chk("wdog_err", err, 1'b1);
                        chk("wdog_req_low", bus_req, 1'b0);
                        chk("wdog_busy_low", busy, 1'b0);
                        chk("wdog_rd_data", rd_data, model_vec());
                    end
                end
                @(negedge clk);
                chk("wdog_err_single", err, 1'b0);
                chk("wdog_no_done", done, 1'b0);
                return;
            end
            d = $urandom_range(dhi, dlo);
            repeat (d) @(negedge clk);
            rd = (rdmode == 1) ? exp_q[t].addr + 8'd1 : (rdmode == 2) ? 8'hAA : DW'($urandom);
            bus_ack = 1'b1; bus_rdata = rd;
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = DW'($urandom);
            if (!exp_q[t].we) record_read(int'(exp_q[t].slot), rd);
            chk("rd_data_live", rd_data, model_vec());
        end
        chk("done_state_req", bus_req, 1'b0);
        chk("done_state_busy", busy, 1'b1);
        chk("done_early", done, 1'b0);
        commit_done();
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("rd_data_final", rd_data, model_vec());
        @(negedge clk);
        chk("done_single", done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        mask = '0; addr_list = '0;
        start0 = 1'b0; abort0 = 1'b0; ack0 = 1'b0; addr0 = '0; mask0 = '0; rdata0 = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", bus_req, 1'b0);   chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 0);    chk("rst_wdata", bus_wdata, 0);
        chk("rst_rd_data", rd_data, 0);  chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);     chk("rst_err", err, 1'b0);
        chk("rst_aborted", aborted, 1'b0);
        reset = 1'b0;

        // Full sequence with the default list and a 2-cycle ack delay.
        addr_list = {8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};
        mask = 9'h1FF;
        run_seq(2, 2, 1, -1);
        chk("t1_bank", rd_data, 72'h44_43_42_27_26_25_24_23_22);
        $display("t1 full sequence done, checks=%0d", checks);

        // Preload slots 3-5 with 0xAA, then skip them.
        mask = 9'h038;
        run_seq(0, 1, 2, -1);
        mask = 9'h1C7;
        run_seq(0, 3, 0, -1);
        chk("skip_keep", rd_data[6*DW-1:3*DW], 24'hAAAAAA);
        $display("t2 masked sequence done, checks=%0d", checks);

        // Ack withheld for slot 2 (transaction index NC+2).
        mask = 9'h1FF;
        run_seq(0, 1, 0, NC + 2);
        $display("t3 watchdog done, checks=%0d", checks);

        // Abort during the second command write.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("ab_addr0", bus_addr, CB);
        bus_ack = 1'b1;
        @(negedge clk); bus_ack = 1'b0;
        chk("ab_addr1", bus_addr, CB + 8'd1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("ab_req_low", bus_req, 1'b0);
        chk("ab_pulse", aborted, 1'b1);
        chk("ab_busy", busy, 1'b0);
        chk("ab_no_done", done, 1'b0);
        @(negedge clk);
        chk("ab_single", aborted, 1'b0);
        chk("ab_no_done2", done, 1'b0);
        chk("ab_rd_data", rd_data, model_vec());
        run_seq(0, 2, 0, -1);
        $display("t4 abort and restart done, checks=%0d", checks);

        // Ack held high: one transaction per cycle; a start in mid-sequence must be ignored.
        addr_list = {$urandom, $urandom, $urandom};
        mask = 9'h1FF;
        build_expected();
        @(negedge clk); start = 1'b1; bus_ack = 1'b1;
        for (int c = 1; c <= NC + NR; c++) begin
            @(negedge clk);
            start = (c == 5);
            chk("hold_req", bus_req, 1'b1);
            chk("hold_addr", bus_addr, exp_q[c-1].addr);
            bus_rdata = DW'($urandom);
            if (!exp_q[c-1].we) record_read(int'(exp_q[c-1].slot), bus_rdata);
        end
        @(negedge clk);
        start = 1'b0;
        chk("hold_done_state_req", bus_req, 1'b0);
        chk("hold_done_early", done, 1'b0);
        commit_done();
        @(negedge clk);
        chk("hold_done_at_13", done, 1'b1);
        chk("hold_rd_data", rd_data, model_vec());
        @(negedge clk);
        chk("hold_no_restart", bus_req, 1'b0);
        chk("hold_idle", busy, 1'b0);
        bus_ack = 1'b0;
        $display("t5 back-to-back done, checks=%0d", checks);

        // Reset in the middle of the read phase.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; bus_ack = 1'b1;
        @(negedge clk);
        @(negedge clk); bus_ack = 1'b0;
        chk("mid_read_we", bus_we, 1'b0);
        chk("mid_read_req", bus_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_req", bus_req, 1'b0);  chk("mrst_addr", bus_addr, 0);
        chk("mrst_we", bus_we, 1'b0);    chk("mrst_rd_data", rd_data, 0);
        chk("mrst_busy", busy, 1'b0);    chk("mrst_done", done, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        $display("t6 mid-read reset done, checks=%0d", checks);

        // Empty mask with no commands: done two cycles after start, never a request.
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        chk("e0_req", req0, 1'b0);
        chk("e0_busy", busy0, 1'b1);
        chk("e0_done_early", done0, 1'b0);
        @(negedge clk);
        chk("e0_done", done0, 1'b1);
        chk("e0_req2", req0, 1'b0);
        chk("e0_busy2", busy0, 1'b0);
        @(negedge clk);
        chk("e0_done_single", done0, 1'b0);
        $display("t7 empty mask done, checks=%0d", checks);

        // Random masks, addresses and ack delays.
        for (int r = 0; r < 4; r++) begin
            addr_list = {$urandom, $urandom, $urandom};
            mask = NR'($urandom);
            run_seq(0, 3, 0, -1);
            $display("t8 random sequence %0d mask=%03h done, checks=%0d", r, mask, checks);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
